// File: rtl/mux32_scan_ctrl.sv
// Scan controller for an external 32:1 mux: walks the enabled channels in
// ascending order, lets each settle for dwell cycles, then captures mux_out.
module mux32_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic [4:0]         sel,
  output logic               busy,
  output logic               done,
  output logic [31:0]        sample_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [4:0]           sel_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic [31:0]          mask_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic                 busy_q;
  logic                 done_q;
  logic [31:0]          sampleVec_q;

  logic [4:0]           firstSel_d;
  logic [4:0]           nextSel_d;
  logic                 nextFound_d;

  // Lowest set bit of the live mask, and next set bit above sel in the latched mask.
  always_comb begin
    firstSel_d  = '0;
    nextSel_d   = '0;
    nextFound_d = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i]) begin
        firstSel_d = 5'(i);
      end
      if (mask_q[i] && (i > int'(sel_q))) begin
        nextSel_d   = 5'(i);
        nextFound_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      dwell_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sampleVec_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            mask_q  <= mask;
            dwell_q <= dwell;
            if (mask != 32'd0) begin
              state_q <= SCAN;
              sel_q   <= firstSel_d;
              cnt_q   <= dwell;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          // Abort wins over the capture that would otherwise happen this edge.
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else begin
            sampleVec_q[sel_q] <= mux_out;
            cnt_q              <= dwell_q;
            if (nextFound_d) begin
              sel_q <= nextSel_d;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_vec = sampleVec_q;

endmodule

// File: tb/tb_mux32_scan_ctrl.sv
// Directed bench for mux32_scan_ctrl; the external 32:1 mux is modelled
// as a data word indexed by sel.
module tb_mux32_scan_ctrl;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [31:0]   mask;
  logic [DW-1:0] dwell;
  logic          mux_out;
  logic [4:0]    sel;
  logic          busy;
  logic          done;
  logic [31:0]   sample_vec;
  logic [31:0]   muxData;

  int checkCount = 0;
  int errorCount = 0;

  logic [4:0] selLog [64];
  logic       busyLog[64];
  logic       doneLog[64];

  always #5 clk = ~clk;

  assign mux_out = muxData[sel];

  mux32_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mask       (mask),
    .dwell      (dwell),
    .mux_out    (mux_out),
    .sel        (sel),
    .busy       (busy),
    .done       (done),
    .sample_vec (sample_vec)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Called just after a falling edge; start is accepted on the next rising edge.
  task automatic applyStimulus(input logic [31:0] m, input logic [DW-1:0] d);
    start = 1'b1;
    mask  = m;
    dwell = d;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic sampleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      selLog[i]  = sel;
      busyLog[i] = busy;
      doneLog[i] = done;
    end
  endtask

  function automatic int countBusy(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (busyLog[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int countDone(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (doneLog[i] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    rst_n   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    mask    = '0;
    dwell   = '0;
    muxData = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_sel", 32'(sel), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_vec", sample_vec, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two channels, dwell 2
    muxData = 32'h0000_0001;
    applyStimulus(32'h0000_0005, 4'd2);
    sampleCycles(8);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("p1_sel%0d", i), 32'(selLog[i]), (i < 3) ? 32'd0 : 32'd2);
    checkOutput("p1_busycnt", 32'(countBusy(8)), 32'd6);
    checkOutput("p1_donepos", 32'(doneLog[6]), 32'd1);
    checkOutput("p1_donecnt", 32'(countDone(8)), 32'd1);
    checkOutput("p1_vec", sample_vec, 32'h0000_0001);

    // All channels, dwell 0, mux_out = sel[0]
    muxData = 32'hAAAA_AAAA;
    applyStimulus(32'hFFFF_FFFF, 4'd0);
    sampleCycles(34);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("p2_sel%0d", i), 32'(selLog[i]), 32'(i));
    checkOutput("p2_busycnt", 32'(countBusy(34)), 32'd32);
    checkOutput("p2_donepos", 32'(doneLog[32]), 32'd1);
    checkOutput("p2_donecnt", 32'(countDone(34)), 32'd1);
    checkOutput("p2_vec", sample_vec, 32'hAAAA_AAAA);

    // Empty mask
    applyStimulus(32'h0, 4'd5);
    sampleCycles(3);
    checkOutput("p3_donepos", 32'(doneLog[0]), 32'd1);
    checkOutput("p3_donecnt", 32'(countDone(3)), 32'd1);
    checkOutput("p3_busycnt", 32'(countBusy(3)), 32'd0);
    checkOutput("p3_sel", 32'(sel), 32'd31);
    checkOutput("p3_vec", sample_vec, 32'hAAAA_AAAA);

    // Abort on the second cycle at sel 31
    muxData = 32'h0000_0001;
    applyStimulus(32'h8000_0001, 4'd3);
    sampleCycles(5);
    checkOutput("p4_sel3", 32'(selLog[3]), 32'd0);
    checkOutput("p4_sel4", 32'(selLog[4]), 32'd31);
    @(negedge clk);
    checkOutput("p4_selabort", 32'(sel), 32'd31);
    checkOutput("p4_busyabort", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    sampleCycles(4);
    checkOutput("p4_busycnt", 32'(countBusy(4)), 32'd0);
    checkOutput("p4_donecnt", 32'(countDone(4)), 32'd0);
    checkOutput("p4_vec", sample_vec, 32'hAAAA_AAAB);

    // Abort on what would be the capture edge
    muxData = 32'h0;
    applyStimulus(32'h0000_0002, 4'd0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    sampleCycles(3);
    checkOutput("p5_busycnt", 32'(countBusy(3)), 32'd0);
    checkOutput("p5_donecnt", 32'(countDone(3)), 32'd0);
    checkOutput("p5_vec", sample_vec, 32'hAAAA_AAAB);

    // Restart attempt and mask/dwell change mid-pass
    muxData = 32'h0000_0100;
    applyStimulus(32'h0000_0106, 4'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      selLog[i]  = sel;
      busyLog[i] = busy;
      doneLog[i] = done;
      if (i == 1) begin
        start = 1'b1;
        mask  = 32'hFFFF_FFFF;
        dwell = 4'd3;
      end
      if (i == 7) start = 1'b0;
    end
    checkOutput("p6_sel0", 32'(selLog[1]), 32'd1);
    checkOutput("p6_sel1", 32'(selLog[3]), 32'd2);
    checkOutput("p6_sel2", 32'(selLog[4]), 32'd8);
    checkOutput("p6_sel3", 32'(selLog[5]), 32'd8);
    checkOutput("p6_busycnt", 32'(countBusy(10)), 32'd6);
    checkOutput("p6_donepos", 32'(doneLog[6]), 32'd1);
    checkOutput("p6_donecnt", 32'(countDone(10)), 32'd1);
    checkOutput("p6_vec", sample_vec, 32'hAAAA_ABA9);

    // Reset mid-pass, then a fresh pass
    muxData = 32'hFFFF_FFFF;
    applyStimulus(32'hFFFF_FFFF, 4'd1);
    sampleCycles(4);
    checkOutput("p7_selpre", 32'(sel), 32'd1);
    checkOutput("p7_busypre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("p7_sel", 32'(sel), 32'd0);
    checkOutput("p7_busy", 32'(busy), 32'd0);
    checkOutput("p7_done", 32'(done), 32'd0);
    checkOutput("p7_vec", sample_vec, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sampleCycles(10);
    checkOutput("p7_busycnt", 32'(countBusy(10)), 32'd0);
    checkOutput("p7_donecnt", 32'(countDone(10)), 32'd0);
    muxData = 32'h0000_0001;
    applyStimulus(32'h0000_0001, 4'd0);
    sampleCycles(3);
    checkOutput("p8_sel", 32'(selLog[0]), 32'd0);
    checkOutput("p8_busy", 32'(busyLog[0]), 32'd1);
    checkOutput("p8_donepos", 32'(doneLog[1]), 32'd1);
    checkOutput("p8_donecnt", 32'(countDone(3)), 32'd1);
    checkOutput("p8_vec", sample_vec, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
